// File: rtl/npc_btb_if.sv
// npc_btb_if: fetch/execute-side signal bundle of the next-PC generator.
//   master : fetch/execute side; drives stall and the resolve (ex_*) fields,
//            receives pc, prediction and flush.
//   slave  : the npc_btb block itself.
interface npc_btb_if;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_npcop;
    logic [25:0] ex_imm;
    logic [31:0] ex_rd;
    logic        ex_cond;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush;
    modport master (
        output stall, ex_valid, ex_pc, ex_npcop, ex_imm, ex_rd, ex_cond, ex_pred_taken, ex_pred_target,
        input  pc, pred_taken, pred_target, flush
    );
    modport slave (
        input  stall, ex_valid, ex_pc, ex_npcop, ex_imm, ex_rd, ex_cond, ex_pred_taken, ex_pred_target,
        output pc, pred_taken, pred_target, flush
    );
endinterface

// File: rtl/npc_btb.sv
// npc_btb: fetch PC register with direct-mapped BTB prediction and execute-stage redirect.
//   clk, rst : clock, synchronous active-high reset
//   bus_io   : npc_btb_if.slave -- stall, pc, pred_taken/pred_target, ex_* resolve fields, flush
// Op codes: 0 PLUS4, 1 BRANCH, 2 JUMP, 3 JR, 4 JALR; anything else behaves as PLUS4.
module npc_btb #(
    parameter int         BTB_DEPTH = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [1:0] CTR_ALLOC = 2'b10
) (
    input logic       clk,
    input logic       rst,
    npc_btb_if.slave  bus_io
);
    localparam int IDX = $clog2(BTB_DEPTH);
    localparam int TW = 30 - IDX;
    localparam logic [3:0] NPC_BRANCH = 4'd1, NPC_JUMP = 4'd2, NPC_JR = 4'd3, NPC_JALR = 4'd4;
    logic [31:0]   pc_q, pc_d;
    logic          valid_q [BTB_DEPTH];
    logic [TW-1:0] tag_q [BTB_DEPTH];
    logic [31:0]   tgt_q [BTB_DEPTH];
    logic [1:0]    ctr_q [BTB_DEPTH];
    logic [IDX-1:0] r_idx, w_idx;
    logic          hit, w_hit, pt, taken, ctl, mis;
    logic [31:0]   ptgt, p4, tgt, actual;
    logic [3:0]    op;
    always_comb begin
        op = bus_io.ex_npcop;
        r_idx = pc_q[IDX+1:2];
        hit = valid_q[r_idx] && tag_q[r_idx] == pc_q[31:IDX+2];
        pt = hit && ctr_q[r_idx][1];
        ptgt = pt ? tgt_q[r_idx] : pc_q + 32'd4;
        p4 = bus_io.ex_pc + 32'd4;
        // ctl marks the ops that train the BTB; unknown codes fall back to PLUS4
        ctl = op == NPC_BRANCH || op == NPC_JUMP || op == NPC_JR || op == NPC_JALR;
        taken = op == NPC_BRANCH ? bus_io.ex_cond : ctl;
        tgt = op == NPC_BRANCH ? p4 + {{14{bus_io.ex_imm[15]}}, bus_io.ex_imm[15:0], 2'b00} :
              op == NPC_JUMP   ? {p4[31:28], bus_io.ex_imm, 2'b00} : bus_io.ex_rd;
        actual = taken ? tgt : p4;
        mis = bus_io.ex_valid && (taken != bus_io.ex_pred_taken || (taken && tgt != bus_io.ex_pred_target));
        pc_d = mis ? actual : bus_io.stall ? pc_q : ptgt;
        w_idx = bus_io.ex_pc[IDX+1:2];
        w_hit = valid_q[w_idx] && tag_q[w_idx] == bus_io.ex_pc[31:IDX+2];
    end
    assign bus_io.pc = pc_q;
    assign bus_io.pred_taken = pt;
    assign bus_io.pred_target = ptgt;
    assign bus_io.flush = mis && !rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i] <= 2'b01;
            end
        end else begin
            pc_q <= pc_d;
            if (bus_io.ex_valid && ctl && w_hit) begin
                if (taken) tgt_q[w_idx] <= tgt;
                ctr_q[w_idx] <= taken ? (&ctr_q[w_idx] ? 2'b11 : ctr_q[w_idx] + 2'd1)
                                      : (|ctr_q[w_idx] ? ctr_q[w_idx] - 2'd1 : 2'b00);
            end else if (bus_io.ex_valid && ctl && taken) begin
                valid_q[w_idx] <= 1'b1;
                tag_q[w_idx] <= bus_io.ex_pc[31:IDX+2];
                tgt_q[w_idx] <= tgt;
                ctr_q[w_idx] <= CTR_ALLOC;
            end
        end
    end
endmodule

// File: tb/tb_npc_btb.sv
// tb_npc_btb: directed self-checking bench for npc_btb (BTB_DEPTH=16, RESET_PC=3000).
module tb_npc_btb;
    localparam logic [3:0] BR = 4'd1, JMP = 4'd2, JR = 4'd3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0;
    int total = 0;
    npc_btb_if bif ();
    npc_btb #(.BTB_DEPTH(16), .RESET_PC(32'h0000_3000), .CTR_ALLOC(2'b10)) dut (
        .clk(clk), .rst(rst), .bus_io(bif)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask
    task automatic res(input logic [3:0] op, input logic [31:0] epc, input logic [25:0] imm,
                       input logic [31:0] rd, input logic cond, input logic ptk, input logic [31:0] ptg);
        bif.ex_valid = 1'b1;
        bif.ex_npcop = op;
        bif.ex_pc = epc;
        bif.ex_imm = imm;
        bif.ex_rd = rd;
        bif.ex_cond = cond;
        bif.ex_pred_taken = ptk;
        bif.ex_pred_target = ptg;
        #1;
    endtask
    task automatic idle();
        bif.ex_valid = 1'b0;
        bif.ex_npcop = 4'd0;
        bif.ex_pc = 32'd0;
        bif.ex_imm = 26'd0;
        bif.ex_rd = 32'd0;
        bif.ex_cond = 1'b0;
        bif.ex_pred_taken = 1'b0;
        bif.ex_pred_target = 32'd0;
        #1;
    endtask
    initial begin
        bif.stall = 1'b0;
        idle();
        tick();
        tick();
        res(BR, 32'h3008, 26'hFFFE, 0, 1, 0, 0);
        chk("flush_during_rst", bif.flush, 0);
        tick();
        chk("pc_rst_wins", bif.pc, 32'h3000);
        rst = 1'b0;
        idle();
        chk("rst_pred_taken", bif.pred_taken, 0);
        chk("rst_pred_target", bif.pred_target, 32'h3004);
        chk("rst_flush", bif.flush, 0);
        tick();
        chk("pc_seq1", bif.pc, 32'h3004);
        tick();
        chk("pc_seq2", bif.pc, 32'h3008);
        chk("no_alloc_in_rst", bif.pred_taken, 0);
        res(BR, 32'h3008, 26'hFFFE, 0, 1, 0, 0);
        chk("br_taken_flush", bif.flush, 1);
        tick();
        chk("br_redirect", bif.pc, 32'h3004);
        idle();
        chk("pred_3004_miss", bif.pred_taken, 0);
        tick();
        chk("pc_back_3008", bif.pc, 32'h3008);
        chk("pred_3008_taken", bif.pred_taken, 1);
        chk("pred_3008_target", bif.pred_target, 32'h3004);
        res(BR, 32'h3008, 26'hFFFE, 0, 0, 1, 32'h3004);
        chk("br_nt_flush", bif.flush, 1);
        chk("same_cycle_old_pred", bif.pred_taken, 1);
        tick();
        chk("br_nt_redirect", bif.pc, 32'h300C);
        res(BR, 32'h3008, 26'hFFFE, 0, 0, 0, 0);
        chk("br_nt2_no_flush", bif.flush, 0);
        tick();
        chk("pc_3010", bif.pc, 32'h3010);
        res(JR, 32'h3010, 0, 32'h0040_0000, 0, 1, 32'h3010);
        chk("jr_flush", bif.flush, 1);
        tick();
        chk("jr_redirect", bif.pc, 32'h0040_0000);
        res(JR, 32'h3010, 0, 32'h0040_0000, 0, 1, 32'h0040_0000);
        chk("jr_correct_no_flush", bif.flush, 0);
        tick();
        chk("pc_400004", bif.pc, 32'h0040_0004);
        res(JR, 32'h0040_0004, 0, 32'h3008, 0, 0, 0);
        chk("jr_back_flush", bif.flush, 1);
        tick();
        chk("pc_3008_again", bif.pc, 32'h3008);
        idle();
        chk("ctr00_pred_taken", bif.pred_taken, 0);
        chk("ctr00_pred_target", bif.pred_target, 32'h300C);
        bif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", bif.pc, 32'h3008);
        end
        res(JMP, 32'h3008, 26'h400, 0, 0, 0, 0);
        chk("stall_jump_flush", bif.flush, 1);
        tick();
        chk("stall_redirect", bif.pc, 32'h1000);
        bif.stall = 1'b0;
        res(BR, 32'h1000, 26'h0010, 0, 1, 0, 0);
        chk("alias_a_flush", bif.flush, 1);
        tick();
        chk("pc_1044", bif.pc, 32'h1044);
        res(JR, 32'h1044, 0, 32'h1000, 0, 0, 0);
        tick();
        chk("pc_1000", bif.pc, 32'h1000);
        idle();
        chk("alias_a_hit", bif.pred_taken, 1);
        chk("alias_a_target", bif.pred_target, 32'h1044);
        res(BR, 32'h1040, 26'h0004, 0, 1, 0, 0);
        chk("alias_b_flush", bif.flush, 1);
        tick();
        chk("pc_1054", bif.pc, 32'h1054);
        res(JR, 32'h1054, 0, 32'h1000, 0, 0, 0);
        tick();
        chk("pc_1000_again", bif.pc, 32'h1000);
        idle();
        chk("alias_replaced_miss", bif.pred_taken, 0);
        chk("alias_replaced_tgt", bif.pred_target, 32'h1004);
        res(JR, 32'h1000, 0, 32'hFFFF_FFFC, 0, 0, 0);
        tick();
        chk("pc_fffffffc", bif.pc, 32'hFFFF_FFFC);
        idle();
        chk("wrap_pred_taken", bif.pred_taken, 0);
        chk("wrap_pred_target", bif.pred_target, 32'h0);
        tick();
        chk("pc_wrap_0", bif.pc, 32'h0);
        res(4'd9, 32'h0, 0, 0, 0, 1, 32'h4);
        chk("unknown_op_flush", bif.flush, 1);
        tick();
        chk("unknown_op_pc", bif.pc, 32'h4);
        idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
